// File: rtl/cpc_ga_pkg.sv
// -----------------------------------------------------------------------------
// cpc_ga_pkg
//   Shared constants for the CPC gate-array memory sequencer: the phase map of
//   the 16-phase 1 us frame, the gate-array command codes carried in d[7:6] of
//   a port 7Fxx write, the reset screen mode and the CPU slot operation type.
//   No ports (package).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package cpc_ga_pkg;

    // Frame phase map. Phases 0-7 hold two video fetches, phases 8-15 one CPU slot.
    localparam logic [3:0] PH_VID0_RAS  = 4'd1;   // first RAS-low phase of a video fetch
    localparam logic [3:0] PH_VID_LAST  = 4'd3;   // last phase of a 4-phase video fetch
    localparam logic [3:0] PH_CPU_START = 4'd8;   // CPU owns the address mux from here
    localparam logic [3:0] PH_CPU_RAS   = 4'd9;   // CPU RAS / ROM / RAM-read window start
    localparam logic [3:0] PH_CAS       = 4'd11;
    localparam logic [3:0] PH_WE        = 4'd12;
    localparam logic [3:0] PH_RDY       = 4'd13;
    localparam logic [3:0] PH_CPU_END   = 4'd14;  // last phase with strobes active
    localparam logic [3:0] PH_REL       = 4'd15;  // WAIT released in this phase

    // Gate-array command codes in d[7:6]; 00/01 (pen/colour) are handled elsewhere.
    localparam logic [1:0] GA_CMD_RMR = 2'b10;
    localparam logic [1:0] GA_CMD_MMR = 2'b11;

    // A15:14 pattern that selects the gate array on an I/O cycle.
    localparam logic [1:0] GA_PORT_A15_14 = 2'b01;

    localparam logic [1:0] RST_SCREEN_MODE = 2'b01;

    typedef enum logic [1:0] {
        SLOT_REFRESH = 2'd0,
        SLOT_READ    = 2'd1,
        SLOT_WRITE   = 2'd2
    } slot_op_e;

    // Inclusive phase-window test.
    function automatic logic ph_in(input logic [3:0] ph,
                                   input logic [3:0] lo,
                                   input logic [3:0] hi);
        return (ph >= lo) && (ph <= hi);
    endfunction

endpackage

// File: rtl/cpc_ga_regs.sv
// -----------------------------------------------------------------------------
// cpc_ga_regs
//   Gate-array I/O register file. Edge-detects a write to port 7Fxx so each
//   OUT updates the registers exactly once, then decodes d[7:6]:
//     RMR (10): screen mode, lower/upper ROM disable, interrupt counter reset
//     MMR (11): 6128 RAM bank (held at 0 when RAM_BANK_EN = 0)
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   ga_sel            gate array selected by the current I/O cycle
//   wr_n              Z80 write strobe
//   data_from_cpu     Z80 data bus
//   screen_mode       video mode register
//   lrom_dis,urom_dis lower / upper ROM disable
//   ram_bank          RAM configuration
//   int_ack           one-clock pulse requesting interrupt counter reset
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module cpc_ga_regs
    import cpc_ga_pkg::*;
#(
    parameter bit RAM_BANK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ga_sel,
    input  logic       wr_n,
    input  logic [7:0] data_from_cpu,
    output logic [1:0] screen_mode,
    output logic       lrom_dis,
    output logic       urom_dis,
    output logic [2:0] ram_bank,
    output logic       int_ack
);

    logic       ga_wr;
    logic       fire;
    logic       ga_wr_q,       ga_wr_d;
    logic [1:0] screen_mode_q, screen_mode_d;
    logic       lrom_dis_q,    lrom_dis_d;
    logic       urom_dis_q,    urom_dis_d;
    logic [2:0] ram_bank_q,    ram_bank_d;
    logic       int_ack_q,     int_ack_d;
    logic       unused_data_bit;

    assign unused_data_bit = data_from_cpu[5];

    always_comb begin
        ga_wr         = ga_sel && !wr_n;
        // A Z80 OUT holds WR low for several clocks; act only on its first one.
        fire          = ga_wr && !ga_wr_q;
        ga_wr_d       = ga_wr;
        screen_mode_d = screen_mode_q;
        lrom_dis_d    = lrom_dis_q;
        urom_dis_d    = urom_dis_q;
        ram_bank_d    = ram_bank_q;
        int_ack_d     = 1'b0;
        if (fire) begin
            case (data_from_cpu[7:6])
                GA_CMD_RMR: begin
                    screen_mode_d = data_from_cpu[1:0];
                    lrom_dis_d    = data_from_cpu[2];
                    urom_dis_d    = data_from_cpu[3];
                    int_ack_d     = data_from_cpu[4];
                end
                GA_CMD_MMR: begin
                    if (RAM_BANK_EN) begin
                        ram_bank_d = data_from_cpu[2:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ga_wr_q       <= 1'b0;
            screen_mode_q <= RST_SCREEN_MODE;
            lrom_dis_q    <= 1'b0;
            urom_dis_q    <= 1'b0;
            ram_bank_q    <= 3'd0;
            int_ack_q     <= 1'b0;
        end else begin
            ga_wr_q       <= ga_wr_d;
            screen_mode_q <= screen_mode_d;
            lrom_dis_q    <= lrom_dis_d;
            urom_dis_q    <= urom_dis_d;
            ram_bank_q    <= ram_bank_d;
            int_ack_q     <= int_ack_d;
        end
    end

    assign screen_mode = screen_mode_q;
    assign lrom_dis    = lrom_dis_q;
    assign urom_dis    = urom_dis_q;
    assign ram_bank    = ram_bank_q;
    assign int_ack     = int_ack_q;

endmodule

// File: rtl/ga_mem_sequencer.sv
// -----------------------------------------------------------------------------
// ga_mem_sequencer
//   Gate-array memory timing sequencer for the CPC core. A free-running 4-bit
//   phase counter splits each 1 us frame into two video fetches (phases 0-7)
//   and one CPU slot (phases 8-15). All DRAM/ROM strobes are registered and
//   decoded from the next phase so they change cleanly on the clock edge.
//   Z80 WAIT is held until the CPU slot that services the access ends.
// Ports
//   clk, reset_n                 16 MHz clock, asynchronous active-low reset
//   cpu_addr, data_from_cpu      Z80 address / data out
//   mreq_n, iorq_n, rd_n, wr_n   Z80 strobes
//   cpu_wait_n                   Z80 WAIT
//   phase, vram_lsb              frame phase, video byte address LSB
//   ras_n, cas_n, mwe_n          DRAM strobes to the memory manager
//   cpu_n                        0 = CPU owns the RAM address mux
//   ready                        latch enable for CPU read data
//   romen_n, ramrd_n, en244_n    ROM select, RAM read, GA data transceiver
//   ram_bank, screen_mode        6128 RAM configuration, video mode
//   int_ack                      interrupt counter reset pulse
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module ga_mem_sequencer
    import cpc_ga_pkg::*;
#(
    parameter bit VIDEO_EN    = 1'b1,
    parameter bit RAM_BANK_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  data_from_cpu,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    output logic        cpu_wait_n,
    output logic [3:0]  phase,
    output logic        vram_lsb,
    output logic        ras_n,
    output logic        cas_n,
    output logic        mwe_n,
    output logic        cpu_n,
    output logic        ready,
    output logic        romen_n,
    output logic        ramrd_n,
    output logic        en244_n,
    output logic [2:0]  ram_bank,
    output logic [1:0]  screen_mode,
    output logic        int_ack
);

    logic [3:0] phase_q,   phase_d;
    logic       pending_q, pending_d;
    logic       served_q,  served_d;
    logic       wait_n_q,  wait_n_d;
    logic       ras_n_q,   ras_n_d;
    logic       cas_n_q,   cas_n_d;
    logic       mwe_n_q,   mwe_n_d;
    logic       cpu_n_q,   cpu_n_d;
    logic       ready_q,   ready_d;
    logic       romen_n_q, romen_n_d;
    logic       ramrd_n_q, ramrd_n_d;

    logic       ga_sel;
    logic       lrom_dis;
    logic       urom_dis;
    logic       rom_sel;
    slot_op_e   slot_op;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[13:0];

    // Purely combinational from the Z80 strobes so the transceiver follows IORQ.
    assign ga_sel  = !iorq_n && (cpu_addr[15:14] == GA_PORT_A15_14);
    assign en244_n = !ga_sel;

    cpc_ga_regs #(
        .RAM_BANK_EN (RAM_BANK_EN)
    ) u_regs (
        .clk           (clk),
        .reset_n       (reset_n),
        .ga_sel        (ga_sel),
        .wr_n          (wr_n),
        .data_from_cpu (data_from_cpu),
        .screen_mode   (screen_mode),
        .lrom_dis      (lrom_dis),
        .urom_dis      (urom_dis),
        .ram_bank      (ram_bank),
        .int_ack       (int_ack)
    );

    always_comb begin
        phase_d = phase_q + 4'd1;

        if (!wr_n) begin
            slot_op = SLOT_WRITE;
        end else if (!rd_n) begin
            slot_op = SLOT_READ;
        end else begin
            slot_op = SLOT_REFRESH;
        end

        rom_sel = ((cpu_addr[15:14] == 2'b00) && !lrom_dis) ||
                  ((cpu_addr[15:14] == 2'b11) && !urom_dis);

        // The slot is claimed at the 7->8 boundary; a request arriving later waits a frame.
        pending_d = pending_q;
        if (phase_q == PH_CPU_START - 4'd1) begin
            pending_d = !mreq_n && !served_q;
        end else if (phase_q == PH_REL) begin
            pending_d = 1'b0;
        end

        // served keeps a still-asserted MREQ from being serviced twice.
        served_d = served_q;
        if (mreq_n) begin
            served_d = 1'b0;
        end else if (pending_q && (phase_q == PH_CPU_END)) begin
            served_d = 1'b1;
        end

        wait_n_d  = mreq_n || served_d;

        ras_n_d   = 1'b1;
        cas_n_d   = 1'b1;
        mwe_n_d   = 1'b1;
        cpu_n_d   = 1'b1;
        ready_d   = 1'b0;
        romen_n_d = 1'b1;
        ramrd_n_d = 1'b1;

        if (!phase_d[3]) begin
            // Two identical 4-phase video fetches: RAS in phases 1-3, CAS in 2-3.
            if (VIDEO_EN) begin
                ras_n_d = !ph_in({2'b00, phase_d[1:0]}, PH_VID0_RAS, PH_VID_LAST);
                cas_n_d = !phase_d[1];
            end
        end else begin
            cpu_n_d = 1'b0;
            if (pending_q) begin
                ras_n_d = !ph_in(phase_d, PH_CPU_RAS, PH_CPU_END);
                if (slot_op != SLOT_REFRESH) begin
                    cas_n_d = !ph_in(phase_d, PH_CAS, PH_CPU_END);
                    ready_d = ph_in(phase_d, PH_RDY, PH_CPU_END);
                end
                // Writes go to RAM even where a ROM is mapped for reads.
                if (slot_op == SLOT_WRITE) begin
                    mwe_n_d = !ph_in(phase_d, PH_WE, PH_RDY);
                end
                if (slot_op == SLOT_READ) begin
                    if (rom_sel) begin
                        romen_n_d = !ph_in(phase_d, PH_CPU_RAS, PH_CPU_END);
                    end else begin
                        ramrd_n_d = !ph_in(phase_d, PH_CPU_RAS, PH_CPU_END);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= 4'd0;
            pending_q <= 1'b0;
            served_q  <= 1'b0;
            wait_n_q  <= 1'b1;
            ras_n_q   <= 1'b1;
            cas_n_q   <= 1'b1;
            mwe_n_q   <= 1'b1;
            cpu_n_q   <= 1'b1;
            ready_q   <= 1'b0;
            romen_n_q <= 1'b1;
            ramrd_n_q <= 1'b1;
        end else begin
            phase_q   <= phase_d;
            pending_q <= pending_d;
            served_q  <= served_d;
            wait_n_q  <= wait_n_d;
            ras_n_q   <= ras_n_d;
            cas_n_q   <= cas_n_d;
            mwe_n_q   <= mwe_n_d;
            cpu_n_q   <= cpu_n_d;
            ready_q   <= ready_d;
            romen_n_q <= romen_n_d;
            ramrd_n_q <= ramrd_n_d;
        end
    end

    assign phase      = phase_q;
    assign vram_lsb   = phase_q[2] && !phase_q[3];
    assign cpu_wait_n = wait_n_q;
    assign ras_n      = ras_n_q;
    assign cas_n      = cas_n_q;
    assign mwe_n      = mwe_n_q;
    assign cpu_n      = cpu_n_q;
    assign ready      = ready_q;
    assign romen_n    = romen_n_q;
    assign ramrd_n    = ramrd_n_q;

endmodule

// File: tb/tb_ga_mem_sequencer.sv
`timescale 1ns/1ps
module tb_ga_mem_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic [7:0]  data_from_cpu;
    logic        mreq_n, iorq_n, rd_n, wr_n;

    logic        cpu_wait_n, vram_lsb, ras_n, cas_n, mwe_n, cpu_n, ready;
    logic        romen_n, ramrd_n, en244_n, int_ack;
    logic [3:0]  phase;
    logic [2:0]  ram_bank;
    logic [1:0]  screen_mode;

    logic        w2_wait_n, w2_vram_lsb, w2_ras_n, w2_cas_n, w2_mwe_n, w2_cpu_n, w2_ready;
    logic        w2_romen_n, w2_ramrd_n, w2_en244_n, w2_int_ack;
    logic [3:0]  w2_phase;
    logic [2:0]  w2_ram_bank;
    logic [1:0]  w2_screen_mode;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ga_mem_sequencer dut (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .data_from_cpu(data_from_cpu),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .cpu_wait_n(cpu_wait_n), .phase(phase), .vram_lsb(vram_lsb),
        .ras_n(ras_n), .cas_n(cas_n), .mwe_n(mwe_n), .cpu_n(cpu_n), .ready(ready),
        .romen_n(romen_n), .ramrd_n(ramrd_n), .en244_n(en244_n),
        .ram_bank(ram_bank), .screen_mode(screen_mode), .int_ack(int_ack)
    );

    // Second instance: no video cycles, no RAM banking (464 build).
    ga_mem_sequencer #(.VIDEO_EN(1'b0), .RAM_BANK_EN(1'b0)) dut2 (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .data_from_cpu(data_from_cpu),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .cpu_wait_n(w2_wait_n), .phase(w2_phase), .vram_lsb(w2_vram_lsb),
        .ras_n(w2_ras_n), .cas_n(w2_cas_n), .mwe_n(w2_mwe_n), .cpu_n(w2_cpu_n), .ready(w2_ready),
        .romen_n(w2_romen_n), .ramrd_n(w2_ramrd_n), .en244_n(w2_en244_n),
        .ram_bank(w2_ram_bank), .screen_mode(w2_screen_mode), .int_ack(w2_int_ack)
    );

    // Expected row: phase + {ras_n, cas_n, mwe_n, cpu_n, ready, romen_n, ramrd_n, cpu_wait_n}
    typedef struct packed {
        logic [3:0] ph;
        logic [7:0] bits;
    } vec_t;

    vec_t tbl [48];

    function automatic vec_t mk(input logic [3:0] ph, input logic [7:0] b);
        vec_t v;
        v.ph   = ph;
        v.bits = b;
        return v;
    endfunction

    function automatic logic [11:0] snap();
        return {phase, ras_n, cas_n, mwe_n, cpu_n, ready, romen_n, ramrd_n, cpu_wait_n};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input logic [3:0] p);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (phase == p) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_phase: phase %0d not reached, now %0d", p, phase);
        end
    endtask

    task automatic run_slot(input int base, input string tag, input logic [3:0] at_ph,
                            input logic [15:0] a, input logic r, input logic w,
                            input logic [7:0] d);
        wait_phase(at_ph);
        cpu_addr      = a;
        data_from_cpu = d;
        rd_n          = r;
        wr_n          = w;
        mreq_n        = 1'b0;
        wait_phase(4'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_ph%0d", tag, tbl[base+i].ph), {4'b0, snap()}, {4'b0, tbl[base+i]});
            if (i < 7) step();
        end
        mreq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
    endtask

    task automatic io_write(input logic [7:0] d, output int pulses);
        pulses        = 0;
        cpu_addr      = 16'h7F00;
        data_from_cpu = d;
        iorq_n        = 1'b0;
        #1;
        check("en244_sel", {15'b0, en244_n}, 16'h0000);
        wr_n = 1'b0;
        repeat (3) begin
            step();
            if (int_ack) pulses++;
        end
        wr_n   = 1'b1;
        iorq_n = 1'b1;
        #1;
        check("en244_desel", {15'b0, en244_n}, 16'h0001);
        repeat (2) begin
            step();
            if (int_ack) pulses++;
        end
    endtask

    initial begin
        int  pulses;
        int  cnt;
        bit  found;
        bit  early;

        // Idle frame
        tbl[0]  = mk(4'd0,  8'b1111_0111);
        tbl[1]  = mk(4'd1,  8'b0111_0111);
        tbl[2]  = mk(4'd2,  8'b0011_0111);
        tbl[3]  = mk(4'd3,  8'b0011_0111);
        tbl[4]  = mk(4'd4,  8'b1111_0111);
        tbl[5]  = mk(4'd5,  8'b0111_0111);
        tbl[6]  = mk(4'd6,  8'b0011_0111);
        tbl[7]  = mk(4'd7,  8'b0011_0111);
        for (int i = 8; i < 16; i++) tbl[i] = mk(i[3:0], 8'b1110_0111);
        // CPU read from ROM
        tbl[16] = mk(4'd8,  8'b1110_0110);
        tbl[17] = mk(4'd9,  8'b0110_0010);
        tbl[18] = mk(4'd10, 8'b0110_0010);
        tbl[19] = mk(4'd11, 8'b0010_0010);
        tbl[20] = mk(4'd12, 8'b0010_0010);
        tbl[21] = mk(4'd13, 8'b0010_1010);
        tbl[22] = mk(4'd14, 8'b0010_1010);
        tbl[23] = mk(4'd15, 8'b1110_0111);
        // CPU read from RAM
        tbl[24] = mk(4'd8,  8'b1110_0110);
        tbl[25] = mk(4'd9,  8'b0110_0100);
        tbl[26] = mk(4'd10, 8'b0110_0100);
        tbl[27] = mk(4'd11, 8'b0010_0100);
        tbl[28] = mk(4'd12, 8'b0010_0100);
        tbl[29] = mk(4'd13, 8'b0010_1100);
        tbl[30] = mk(4'd14, 8'b0010_1100);
        tbl[31] = mk(4'd15, 8'b1110_0111);
        // CPU write
        tbl[32] = mk(4'd8,  8'b1110_0110);
        tbl[33] = mk(4'd9,  8'b0110_0110);
        tbl[34] = mk(4'd10, 8'b0110_0110);
        tbl[35] = mk(4'd11, 8'b0010_0110);
        tbl[36] = mk(4'd12, 8'b0000_0110);
        tbl[37] = mk(4'd13, 8'b0000_1110);
        tbl[38] = mk(4'd14, 8'b0010_1110);
        tbl[39] = mk(4'd15, 8'b1110_0111);
        // Refresh
        tbl[40] = mk(4'd8,  8'b1110_0110);
        for (int i = 41; i < 47; i++) tbl[i] = mk(4'(i - 32), 8'b0110_0110);
        tbl[47] = mk(4'd15, 8'b1110_0111);

        reset_n       = 1'b0;
        cpu_addr      = 16'h0000;
        data_from_cpu = 8'h00;
        mreq_n        = 1'b1;
        iorq_n        = 1'b1;
        rd_n          = 1'b1;
        wr_n          = 1'b1;
        repeat (3) step();

        check("reset_strobes", {4'b0, snap()}, {4'b0, tbl[0]});
        check("reset_regs", {9'b0, en244_n, ram_bank, screen_mode, int_ack}, 16'b0000_0000_0100_0010);

        reset_n = 1'b1;
        step();
        check("phase_after_reset", {12'b0, phase}, 16'd1);

        // Idle frame, plus the video-disabled instance stays quiet
        wait_phase(4'd0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("idle_ph%0d", i), {4'b0, snap()}, {4'b0, tbl[i]});
            check($sformatf("idle_vlsb_ph%0d", i), {15'b0, vram_lsb},
                  {15'b0, (i >= 4 && i < 8) ? 1'b1 : 1'b0});
            check($sformatf("novideo_ph%0d", i), {14'b0, w2_ras_n, w2_cas_n}, 16'd3);
            if (i < 15) step();
        end

        run_slot(16, "rd_rom_1234", 4'd3, 16'h1234, 1'b0, 1'b1, 8'h00);
        run_slot(32, "wr_c000",     4'd4, 16'hC000, 1'b1, 1'b0, 8'h55);
        run_slot(40, "refresh",     4'd4, 16'h0000, 1'b1, 1'b1, 8'h00);

        io_write(8'h8C, pulses);
        check("int_ack_8c", 16'(pulses), 16'd0);
        check("mode_8c", {14'b0, screen_mode}, 16'd0);
        run_slot(24, "rd_ram_c000", 4'd4, 16'hC000, 1'b0, 1'b1, 8'h00);

        io_write(8'hC7, pulses);
        check("int_ack_c7", 16'(pulses), 16'd0);
        check("bank_c7", {13'b0, ram_bank}, 16'd7);
        check("bank_464", {13'b0, w2_ram_bank}, 16'd0);
        check("mode_kept_c7", {14'b0, screen_mode}, 16'd0);

        io_write(8'h94, pulses);
        check("int_ack_94", 16'(pulses), 16'd1);
        run_slot(16, "rd_rom_c000", 4'd4, 16'hC000, 1'b0, 1'b1, 8'h00);
        run_slot(24, "rd_ram_0100", 4'd4, 16'h0100, 1'b0, 1'b1, 8'h00);

        io_write(8'h82, pulses);
        check("mode_82", {14'b0, screen_mode}, 16'd2);
        check("bank_kept_82", {13'b0, ram_bank}, 16'd7);

        // Request arriving after the slot was claimed waits for the next frame
        wait_phase(4'd9);
        cpu_addr = 16'h8000;
        rd_n     = 1'b0;
        mreq_n   = 1'b0;
        cnt      = 0;
        found    = 1'b0;
        early    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            cnt++;
            if (cpu_wait_n) early = 1'b1;
            if (phase == 4'd11 && cas_n == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("late_found", {15'b0, found}, 16'd1);
        check("late_latency", 16'(cnt), 16'd18);
        check("late_ramrd", {15'b0, ramrd_n}, 16'd0);
        check("late_wait_held", {15'b0, early}, 16'd0);
        wait_phase(4'd15);
        check("late_wait_rel", {15'b0, cpu_wait_n}, 16'd1);
        mreq_n = 1'b1;
        rd_n   = 1'b1;

        // Reset in the middle of a write
        wait_phase(4'd4);
        cpu_addr      = 16'h4000;
        data_from_cpu = 8'hAA;
        wr_n          = 1'b0;
        mreq_n        = 1'b0;
        wait_phase(4'd12);
        check("midwr_mwe_low", {15'b0, mwe_n}, 16'd0);
        reset_n = 1'b0;
        #1;
        check("midwr_reset", {4'b0, snap()}, {4'b0, tbl[0]});
        check("midwr_regs", {11'b0, ram_bank, screen_mode}, 16'd1);
        mreq_n = 1'b1;
        wr_n   = 1'b1;
        step();
        step();
        reset_n = 1'b1;
        step();
        check("phase_after_rst2", {12'b0, phase}, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
